// File: rtl/scan_host_pkg.sv
// Shared types and helpers for the host-side scan port master.
package scan_host_pkg;

   typedef enum logic [1:0] {
      SCAN_IN  = 2'b00,
      LOAD     = 2'b01,
      WRITE    = 2'b10,
      SCAN_OUT = 2'b11
   } scan_mode_t;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_RUN  = 2'b01,
      OP_NOP  = 2'b10,
      OP_DUMP = 2'b11
   } host_op_t;

   typedef enum logic [2:0] {
      IDLE,
      LD_FILL,
      LD_WRITE,
      RUN,
      RD_ADDR,
      RD_WAIT,
      RD_EMIT
   } state_t;

   // Host words per scan line.
   function automatic int wpl(input int line_w, input int word_w);
      return line_w / word_w;
   endfunction

endpackage

// File: rtl/scan_line_buf.sv
// One scan line of storage with a word-packing shift path, a parallel capture
// path and a word counter; serves both the load and the dump direction.
module scan_line_buf
   import scan_host_pkg::*;
#(
   parameter int LINE_W = 512,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              shift_en,
   input  logic [WORD_W-1:0] word_in,
   input  logic              capture_en,
   input  logic [LINE_W-1:0] line_in,
   input  logic              advance,
   output logic [LINE_W-1:0] pack_next,
   output logic [WORD_W-1:0] next_word,
   output logic              last_word,
   output logic              next_last
);

   localparam int WPL   = wpl(LINE_W, WORD_W);
   localparam int CNT_W = (WPL > 1) ? $clog2(WPL) : 1;

   logic [LINE_W-1:0] line;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;

   assign cnt_inc   = (cnt == CNT_W'(WPL - 1)) ? '0 : cnt + 1'b1;
   assign last_word = (cnt == CNT_W'(WPL - 1));
   assign next_last = (cnt_inc == CNT_W'(WPL - 1));
   assign next_word = line[int'(cnt_inc) * WORD_W +: WORD_W];

   // Words enter at the top and slide down, so word k ends at bits [k*WORD_W +: WORD_W].
   generate
      if (WPL > 1) begin : g_shift
         assign pack_next = {word_in, line[LINE_W-1:WORD_W]};
      end else begin : g_single
         assign pack_next = word_in;
      end
   endgenerate

   // NOTE: the line buffer is cleared by reset so an aborted partial load can
   // never leak stale words into a later line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line <= '0;
         cnt  <= '0;
      end else if (capture_en) begin
         // NOTE: non-blocking updates keep line and cnt consistent with what
         // every reader sampled in the same cycle.
         line <= line_in;
         cnt  <= '0;
      end else if (shift_en) begin
         line <= pack_next;
         cnt  <= cnt_inc;
      end else if (advance) begin
         cnt  <= cnt_inc;
      end
   end

endmodule

// File: rtl/scan_host_ctrl.sv
// Host master for the CIM scan port: packs word streams into SCAN_IN line
// writes, runs compute for N cycles and unpacks SCAN_OUT lines to a word stream.
module scan_host_ctrl
   import scan_host_pkg::*;
#(
   parameter int LINE_W   = 512,
   parameter int WORD_W   = 32,
   parameter int ADDR_W   = 8,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic [LINE_W-1:0] scan_in,
   output logic [ADDR_W-1:0] scan_addr,
   output logic [1:0]        scan_mode,
   input  logic [LINE_W-1:0] scan_out
);

   localparam int WPL   = wpl(LINE_W, WORD_W);
   localparam int LAT_W = $clog2(READ_LAT + 1);

   state_t            state;
   logic [ADDR_W-1:0] remaining;
   logic [LAT_W-1:0]  wait_cnt;
   logic              shift_en, capture_en, advance;
   logic              last_word, next_last;
   logic [LINE_W-1:0] pack_next;
   logic [WORD_W-1:0] next_word;

   assign cmd_ready  = (state == IDLE);
   assign in_ready   = (state == LD_FILL);
   assign busy       = (state != IDLE);
   assign shift_en   = (state == LD_FILL) && in_valid;
   assign capture_en = (state == RD_WAIT) && (wait_cnt == LAT_W'(READ_LAT));
   assign advance    = (state == RD_EMIT) && out_ready;

   scan_line_buf #(.LINE_W(LINE_W), .WORD_W(WORD_W)) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .shift_en   (shift_en),
      .word_in    (in_data),
      .capture_en (capture_en),
      .line_in    (scan_out),
      .advance    (advance),
      .pack_next  (pack_next),
      .next_word  (next_word),
      .last_word  (last_word),
      .next_last  (next_last)
   );

   // scan_addr doubles as the working line address; SCAN_OUT is the idle mode
   // because reading the memory has no side effects.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         scan_mode <= SCAN_OUT;
         scan_addr <= '0;
         scan_in   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         remaining <= '0;
         wait_cnt  <= '0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               case (host_op_t'(cmd_op))
                  OP_LOAD: begin
                     scan_addr <= cmd_base;
                     remaining <= cmd_len;
                     state     <= LD_FILL;
                  end
                  OP_RUN: begin
                     remaining <= cmd_len;
                     scan_mode <= LOAD;
                     state     <= RUN;
                  end
                  OP_DUMP: begin
                     scan_addr <= cmd_base;
                     remaining <= cmd_len;
                     state     <= RD_ADDR;
                  end
                  default: ;
               endcase
            end
            LD_FILL: if (shift_en && last_word) begin
               scan_in   <= pack_next;
               scan_mode <= SCAN_IN;
               state     <= LD_WRITE;
            end
            LD_WRITE: begin
               scan_mode <= SCAN_OUT;
               if (remaining == '0) begin
                  state <= IDLE;
               end else begin
                  scan_addr <= scan_addr + 1'b1;
                  remaining <= remaining - 1'b1;
                  state     <= LD_FILL;
               end
            end
            RUN: begin
               if (remaining == '0) begin
                  scan_mode <= SCAN_OUT;
                  state     <= IDLE;
               end else begin
                  remaining <= remaining - 1'b1;
               end
            end
            RD_ADDR: begin
               wait_cnt <= LAT_W'(1);
               state    <= RD_WAIT;
            end
            RD_WAIT: begin
               if (capture_en) begin
                  out_data  <= scan_out[WORD_W-1:0];
                  out_valid <= 1'b1;
                  out_last  <= (remaining == '0) && (WPL == 1);
                  state     <= RD_EMIT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RD_EMIT: if (advance) begin
               if (last_word) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (remaining == '0) begin
                     state <= IDLE;
                  end else begin
                     scan_addr <= scan_addr + 1'b1;
                     remaining <= remaining - 1'b1;
                     state     <= RD_ADDR;
                  end
               end else begin
                  out_data <= next_word;
                  out_last <= (remaining == '0) && next_last;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/scan_host_ctrl.md
Name: scan_host_ctrl

Overview:
- Host-side master for the CIM output-memory scan port; it is the opposite end of `scan_in`/`scan_addr`/`scan_mode`/`scan_out`.
- Load: packs a 32-bit word stream into 512-bit lines and writes them with SCAN_IN.
- Run: drives compute mode (`scan_mode`=01) for a programmed number of cycles.
- Dump: reads lines with SCAN_OUT and unpacks them into a 32-bit output stream.
- Sits between the off-chip/test interface and the memory/CIM top.

Parameters:
- LINE_W, 512, scan line width.
- WORD_W, 32, host stream word width; LINE_W must be a multiple of WORD_W.
- ADDR_W, 8, scan address width.
- READ_LAT, 1, clk cycles from driving a SCAN_OUT address to valid `scan_out` (>=1).

Ports:
- clk  in  1  controller clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  00 load, 01 run, 11 dump, 10 no-op.
- cmd_base  in  ADDR_W  first line address.
- cmd_len  in  ADDR_W  lines (load/dump) or run cycles, minus 1.
- in_data  in  WORD_W  load stream data.
- in_valid  in  1  load word offered.
- in_ready  out  1  load word accepted.
- out_data  out  WORD_W  dump stream data.
- out_valid  out  1  dump word valid.
- out_ready  in  1  dump word consumed.
- out_last  out  1  final word of the dump command.
- busy  out  1  state != IDLE.
- scan_in  out  LINE_W  line to write.
- scan_addr  out  ADDR_W  scan address.
- scan_mode  out  2  00 SCAN_IN, 01 run, 11 SCAN_OUT.
- scan_out  in  LINE_W  read line.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; scan_mode=11 (side-effect-free idle).
  - scan_addr=0, scan_in=0.
  - out_valid=0, out_last=0, in_ready=0, busy=0, cmd_ready=1 on release.
  - Line buffer, word and line counters cleared.
- Outputs: all are registered except cmd_ready, in_ready and busy, which are decoded from state.
- Definition: WPL = LINE_W/WORD_W (16 by default).
- IDLE: cmd_ready=1. On accept, latch op/base/len; addr<=base; remaining<=len. Transitions:
  - load -> LD_FILL.
  - run -> RUN.
  - dump -> RD_ADDR.
  - op 10: accepted and dropped; stays IDLE.
- LD_FILL: in_ready=1.
  - Each accepted word shifts into the line buffer; word k of a line lands at bits [k*WORD_W +: WORD_W].
  - After WPL words -> LD_WRITE.
- LD_WRITE: exactly one cycle of scan_mode=00, scan_addr=addr, scan_in=line.
  - Next cycle scan_mode returns to 11.
  - If remaining==0 -> IDLE; else addr++, remaining--, -> LD_FILL.
- RUN: scan_mode=01 for exactly len+1 cycles, then scan_mode=11 -> IDLE.
- RD_ADDR: scan_mode=11, scan_addr=addr; wait READ_LAT cycles (RD_WAIT).
- RD_WAIT: then capture scan_out into the line buffer -> RD_EMIT.
- RD_EMIT:
  - Present words 0..WPL-1 in order; out_valid=1 and out_data stable until out_ready.
  - out_last=1 only with word WPL-1 of the line where remaining==0.
  - After the final handshake: if remaining==0 -> IDLE; else addr++, remaining-- -> RD_ADDR.
- Address wrap: addr increments modulo 2^ADDR_W (0xFF -> 0x00); no error is raised.
- Width: cmd_len=0xFF gives 256 lines/cycles; remaining is ADDR_W bits and counts down to 0.
- Commands while busy: cmd_ready=0, so the command is held off and not lost.
- Stream edges: in_valid outside LD_FILL is ignored (in_ready=0); out_ready outside RD_EMIT is ignored.
- Reset mid-operation: aborts immediately. Partial load lines are discarded (never written); scan_mode returns to 11 asynchronously.

Decomposition:
- Package scan_host_pkg holds:
  - scan_mode_t enum: SCAN_IN=00, LOAD=01, WRITE=10, SCAN_OUT=11. The run phase drives 01; the memory top splits it into load/write by clk phase.
  - host_op_t enum.
  - state_t enum.
  - WPL constant function.
- Sub-module scan_line_buf: LINE_W buffer with a word-shift-in (pack) path, a parallel load (capture), a word-select-out (unpack) path and a word counter. It is shared by load and dump.

Test Plan:
- Load base=0x10 len=1, words 0..31 with in_valid gaps:
  - scan_mode=00 for one cycle at addr 0x10 with scan_in word k=k, then at 0x11 with words 16..31.
  - No other 00 cycles.
- Dump base=0x10 len=1, memory model returning the loaded lines, out_ready toggling 1/0:
  - out_data 0..31 in order, each word held while stalled.
  - out_last only on word 31.
- Load base=0xFF len=1:
  - Writes at 0xFF then 0x00.
  - Dump base=0xFF len=0 returns the 0xFF line only, with out_last on word 15.
- Run len=3:
  - scan_mode=01 for exactly 4 cycles, then 11.
  - cmd_ready=0 throughout; a second cmd held valid is accepted on the first IDLE cycle.
- Reset asserted after 5 words of a load (and separately mid-dump):
  - Outputs return to reset values immediately; no 00 cycle occurs.
  - A fresh load afterwards writes a clean line.
- cmd_op=10: accepted in one cycle; busy stays 0; no scan_mode change.
